// File: rtl/rat_alu_seq_if.sv
// Operand/result bundle for rat_alu_seq: the request side (START, SEL, A, B, CIN)
// and the registered completion side (RESULT, RESULT_HI, C, Z, BUSY, DONE).
interface rat_alu_seq_if #(
   parameter int WIDTH = 8
);
   logic             START;
   logic [4:0]       SEL;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             CIN;
   logic [WIDTH-1:0] RESULT;
   logic [WIDTH-1:0] RESULT_HI;
   logic             C;
   logic             Z;
   logic             BUSY;
   logic             DONE;

   modport master (
      output START, SEL, A, B, CIN,
      input  RESULT, RESULT_HI, C, Z, BUSY, DONE
   );

   modport slave (
      input  START, SEL, A, B, CIN,
      output RESULT, RESULT_HI, C, Z, BUSY, DONE
   );
endinterface

// File: rtl/rat_alu_seq.sv
// Registered RAT ALU: 15 single-cycle ops plus multi-cycle unsigned MUL (shift-add)
// and DIV (restoring). The divider is built only when RAT_ALU_DIV_EN is defined.
module rat_alu_seq #(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic         CLK,
   input  logic         RST,
   rat_alu_seq_if.slave bus
);
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;   // multiplicand or divisor
   logic [WIDTH-1:0] acc_q, acc_d;     // product high half or partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;       // multiplier/product low half or dividend/quotient
   logic [WIDTH-1:0] result_q, result_d;
   logic [WIDTH-1:0] result_hi_q, result_hi_d;
   logic             c_q, c_d;
   logic             z_q, z_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
`ifdef RAT_ALU_DIV_EN
   logic             div_q, div_d;
`endif

   logic [WIDTH:0]   add_s, sub_s, mul_s;
   logic [WIDTH-1:0] alu_res, acc_n, lo_n;
   logic             alu_c, cin_m;

   // Single-cycle datapath, evaluated on the live operands.
   always_comb begin
      cin_m = ((bus.SEL == 5'd1) || (bus.SEL == 5'd3)) ? bus.CIN : 1'b0;
      add_s = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, cin_m};
      sub_s = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, cin_m};
      alu_res = '0;
      alu_c   = 1'b0;
      case (bus.SEL)
         5'd0, 5'd1:        begin alu_res = add_s[WIDTH-1:0]; alu_c = add_s[WIDTH]; end
         5'd2, 5'd3, 5'd4:  begin alu_res = sub_s[WIDTH-1:0]; alu_c = sub_s[WIDTH]; end
         5'd5, 5'd8:        alu_res = bus.A & bus.B;
         5'd6:              alu_res = bus.A | bus.B;
         5'd7:              alu_res = bus.A ^ bus.B;
         5'd9:  begin alu_res = {bus.A[WIDTH-2:0], bus.CIN};      alu_c = bus.A[WIDTH-1]; end
         5'd10: begin alu_res = {bus.CIN, bus.A[WIDTH-1:1]};      alu_c = bus.A[0]; end
         5'd11: begin alu_res = {bus.A[WIDTH-2:0], bus.A[WIDTH-1]}; alu_c = bus.A[WIDTH-1]; end
         5'd12: begin alu_res = {bus.A[0], bus.A[WIDTH-1:1]};     alu_c = bus.A[0]; end
         5'd13: begin alu_res = {bus.A[WIDTH-1], bus.A[WIDTH-1:1]}; alu_c = bus.A[0]; end
         5'd14:             alu_res = bus.B;
         default: begin alu_res = '0; alu_c = 1'b0; end
      endcase
   end

   // One iteration of the multi-cycle datapath.
   always_comb begin
      mul_s = lo_q[0] ? ({1'b0, acc_q} + {1'b0, opnd_q}) : {1'b0, acc_q};
      acc_n = mul_s[WIDTH:1];
      lo_n  = {mul_s[0], lo_q[WIDTH-1:1]};
`ifdef RAT_ALU_DIV_EN
      if (div_q) begin
         // Remainder stays below the divisor, so the W-bit difference is exact.
         if ({acc_q, lo_q[WIDTH-1]} >= {1'b0, opnd_q}) begin
            acc_n = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]} - opnd_q;
            lo_n  = {lo_q[WIDTH-2:0], 1'b1};
         end else begin
            acc_n = {acc_q[WIDTH-2:0], lo_q[WIDTH-1]};
            lo_n  = {lo_q[WIDTH-2:0], 1'b0};
         end
      end
`endif
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      opnd_d      = opnd_q;
      acc_d       = acc_q;
      lo_d        = lo_q;
      result_d    = result_q;
      result_hi_d = result_hi_q;
      c_d         = c_q;
      z_d         = z_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
`ifdef RAT_ALU_DIV_EN
      div_d       = div_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (bus.START) begin
               if (bus.SEL == 5'd15) begin
                  opnd_d  = bus.A;
                  lo_d    = bus.B;
                  acc_d   = '0;
                  cnt_d   = CNT_W'(WIDTH);
                  busy_d  = 1'b1;
                  state_d = S_RUN;
`ifdef RAT_ALU_DIV_EN
                  div_d   = 1'b0;
               end else if (bus.SEL == 5'd16 && bus.B != '0) begin
                  opnd_d  = bus.B;
                  lo_d    = bus.A;
                  acc_d   = '0;
                  cnt_d   = CNT_W'(WIDTH);
                  busy_d  = 1'b1;
                  div_d   = 1'b1;
                  state_d = S_RUN;
               end else if (bus.SEL == 5'd16) begin
                  result_d    = '1;
                  result_hi_d = bus.A;
                  c_d         = 1'b1;
                  z_d         = 1'b0;
                  done_d      = 1'b1;
`endif
               end else begin
                  result_d    = alu_res;
                  result_hi_d = '0;
                  c_d         = alu_c;
                  z_d         = (alu_res == '0);
                  done_d      = 1'b1;
               end
            end
         end
         S_RUN: begin
            acc_d = acc_n;
            lo_d  = lo_n;
            cnt_d = cnt_q - CNT_W'(1);
            // Last bit: publish on this edge so DONE lands WIDTH+1 cycles after START.
            if (cnt_q == CNT_W'(1)) begin
               state_d     = S_FIN;
               result_d    = lo_n;
               result_hi_d = acc_n;
               c_d         = (acc_n != '0);
               z_d         = (acc_n == '0) && (lo_n == '0);
               done_d      = 1'b1;
`ifdef RAT_ALU_DIV_EN
               if (div_q) begin
                  c_d = 1'b0;
                  z_d = (lo_n == '0);
               end
`endif
            end
         end
         S_FIN: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         opnd_q      <= '0;
         acc_q       <= '0;
         lo_q        <= '0;
         result_q    <= '0;
         result_hi_q <= '0;
         c_q         <= 1'b0;
         z_q         <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef RAT_ALU_DIV_EN
         div_q       <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         opnd_q      <= opnd_d;
         acc_q       <= acc_d;
         lo_q        <= lo_d;
         result_q    <= result_d;
         result_hi_q <= result_hi_d;
         c_q         <= c_d;
         z_q         <= z_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
`ifdef RAT_ALU_DIV_EN
         div_q       <= div_d;
`endif
      end
   end

   assign bus.RESULT    = result_q;
   assign bus.RESULT_HI = result_hi_q;
   assign bus.C         = c_q;
   assign bus.Z         = z_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
endmodule

// File: doc/rat_alu_seq.md
Name: rat_alu_seq

Overview:
- Parametrised-width, registered successor of the RAT MCU ALU.
- Performs the existing 15 single-cycle operations plus multi-cycle unsigned MUL and DIV through a START/BUSY/DONE handshake.
- Results and C/Z flags are registered and held until the next completion.
- Sits between the register file/scratch-pad operand muxes and the flag/write-back logic; the control unit waits on DONE.

Parameters:
- WIDTH, 8: operand/result width in bits; must be >= 2.
- CNT_W, $clog2(WIDTH+1): iteration-counter width; derived, do not override.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- START  input  1  one-cycle request; operands are sampled on the CLK edge where START=1 and BUSY=0.
- SEL  input  5  operation select.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- CIN  input  1  carry-in from the C flag.
- RESULT  output  WIDTH  result; for MUL the low product half, for DIV the quotient.
- RESULT_HI  output  WIDTH  MUL high product half, DIV remainder; 0 for all other ops.
- C  output  1  carry/borrow flag, registered.
- Z  output  1  zero flag, registered.
- BUSY  output  1  multi-cycle operation in progress.
- DONE  output  1  one-cycle pulse when RESULT/RESULT_HI/C/Z update.

Behaviour:
- Reset: RST=1 asynchronously clears RESULT, RESULT_HI, C, Z, BUSY, DONE and all internal state to 0. A reset mid-MUL/DIV aborts the operation, and no DONE is issued for it.
- Arithmetic: done at WIDTH+1 bits on zero-extended operands. C = bit WIDTH of the sum or difference; for subtraction this is the borrow, 1 when A < B (+CIN).
- Z: 1 iff RESULT == 0 for ops 0-14. For MUL, Z is 1 iff the full 2*WIDTH product is 0. For DIV, Z is 1 iff the quotient is 0.
- Single-cycle ops are accepted on the START edge. RESULT, C and Z are written on that same edge, and DONE=1 for the following cycle (latency 1). BUSY stays 0.
- Op 0 ADD: A+B.
- Op 1 ADDC: A+B+CIN.
- Op 2 SUB: A-B.
- Op 3 SUBC: A-B-CIN.
- Op 4 CMP: same as SUB.
- Op 5 AND: A&B, C=0.
- Op 6 OR: A|B, C=0.
- Op 7 XOR: A^B, C=0.
- Op 8 TEST: same as AND.
- Op 9 LSL: RESULT={A[W-2:0],CIN}, C=A[W-1].
- Op 10 LSR: RESULT={CIN,A[W-1:1]}, C=A[0].
- Op 11 ROL: RESULT={A[W-2:0],A[W-1]}, C=A[W-1].
- Op 12 ROR: RESULT={A[0],A[W-1:1]}, C=A[0].
- Op 13 ASR: RESULT={A[W-1],A[W-1:1]}, C=A[0].
- Op 14 MOV: RESULT=B, C=0.
- Op 15 MUL: unsigned shift-add, one bit per cycle.
- Op 16 DIV: unsigned restoring division, one bit per cycle.
- Ops 17-31: single-cycle, RESULT=0, RESULT_HI=0, C=0, Z=1.
- FSM states:
  - IDLE: on START with SEL in {15,16}, latch A and B, clear the accumulator, load count=WIDTH, go to RUN, set BUSY=1.
  - RUN: process one bit per cycle and decrement count; at count==1 go to FIN.
  - FIN: write RESULT, RESULT_HI, C and Z; pulse DONE; clear BUSY; return to IDLE.
- MUL/DIV latency: START edge to DONE is WIDTH+1 cycles; BUSY is high for WIDTH+1 cycles.
- MUL flags: C=1 iff the high product half is nonzero (overflow of the low half).
- DIV by zero (B==0): no RUN phase; completes with single-cycle timing. Outputs are RESULT=all ones, RESULT_HI=A, C=1, Z=0.
- START while BUSY=1 is ignored, with no queueing. Operand changes while BUSY do not affect the operation in progress.
- Between completions, all outputs hold their last values. DONE is never asserted for two consecutive cycles unless START is reissued.

Optional Feature:
- Macro RAT_ALU_DIV_EN.
- Defined: SEL 16 is DIV as specified above.
- Undefined: the divider datapath is not built. SEL 16 behaves as the unused ops 17-31 (single-cycle, RESULT=0, RESULT_HI=0, C=0, Z=1). MUL is unaffected.

Test Plan:
- Reset/ADD, WIDTH=8: assert RST mid-MUL, then ADD A=8'hFF, B=8'h01 -> RST clears BUSY with no DONE; ADD gives RESULT=8'h00, C=1, Z=1, DONE one cycle after START.
- SUBC/CMP: SUBC A=8'h05, B=8'h05, CIN=1 -> RESULT=8'hFF, C=1, Z=0; CMP A=8'h10, B=8'h03 -> RESULT=8'h0D, C=0, Z=0.
- Shifts: A=8'h81, CIN=0 -> LSL 8'h02 C=1; LSR 8'h40 C=1; ROL 8'h03 C=1; ROR 8'hC0 C=1; ASR 8'hC0 C=1.
- MUL: A=8'hC8, B=8'h0A -> DONE exactly 9 cycles after START, RESULT=8'hD0, RESULT_HI=8'h07, C=1, Z=0; a second START while BUSY is ignored.
- DIV (RAT_ALU_DIV_EN): A=8'd200, B=8'd7 -> RESULT=8'd28, RESULT_HI=8'd4 after 9 cycles; B=0 -> RESULT=8'hFF, RESULT_HI=8'd200, C=1, DONE after 1 cycle. Without the macro, SEL 16 gives RESULT=0, Z=1.
- WIDTH=16 regression: MUL 16'hFFFF x 16'hFFFF -> RESULT=16'h0001, RESULT_HI=16'hFFFE, C=1, DONE 17 cycles after START.
